// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and sizing helpers for the pipeline hazard/stall controller.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int WAIT_W          = $clog2(DEFAULT_TIMEOUT + 1);

    // Wait counter must be able to hold the value TIMEOUT itself.
    function automatic int waitWidth(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs, pipeline-register control outputs and status counters of the controller.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       id_rs1;
    logic [4:0]       id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic             ex_mem_read;
    logic [4:0]       ex_rd;
    logic             branch_taken;
    logic             dmem_req;
    logic             dmem_ready;

    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_write;
    logic             ex_mem_write;
    logic             mem_wb_write;
    logic             if_id_flush;
    logic             id_ex_bubble;
    logic             bus_error;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_count;

    modport master (
        input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, dmem_req, dmem_ready,
        output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, bus_error, stall_cycles, flush_count
    );

    modport slave (
        output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_mem_read, ex_rd,
               branch_taken, dmem_req, dmem_ready,
        input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
               if_id_flush, id_ex_bubble, bus_error, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_ctrl_load_use_detect.sv
// Combinational load-use comparator: a load in EX feeding a source read by the ID instruction.
module load_use_detect (
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_ex_rd,
    output logic       o_hazard
);

    logic w_rs1Match;
    logic w_rs2Match;

    assign w_rs1Match = i_id_uses_rs1 && (i_id_rs1 == i_ex_rd);
    assign w_rs2Match = i_id_uses_rs2 && (i_id_rs2 == i_ex_rd);

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1Match || w_rs2Match);

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory freeze, branch redirect, load-use bubble and timeout.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    pipeline_ctrl_if.master bus
);

    localparam int WAIT_BITS = waitWidth(TIMEOUT);

    ctrl_state_t           r_state;
    ctrl_state_t           w_nextState;
    logic [WAIT_BITS-1:0]  r_waitCnt;
    logic [WAIT_BITS-1:0]  w_waitCntInc;
    logic [CNT_W-1:0]      r_stallCycles;
    logic [CNT_W-1:0]      r_flushCount;

    logic w_hazard;
    logic w_memStall;
    logic w_timeout;
    logic w_redirect;
    logic w_pcWrite;
    logic w_ifIdWrite;
    logic w_idExWrite;
    logic w_exMemWrite;
    logic w_memWbWrite;
    logic w_ifIdFlush;
    logic w_idExBubble;

    load_use_detect u_load_use_detect (
        .i_id_rs1      (bus.id_rs1),
        .i_id_rs2      (bus.id_rs2),
        .i_id_uses_rs1 (bus.id_uses_rs1),
        .i_id_uses_rs2 (bus.id_uses_rs2),
        .i_ex_mem_read (bus.ex_mem_read),
        .i_ex_rd       (bus.ex_rd),
        .o_hazard      (w_hazard)
    );

    assign w_memStall   = bus.dmem_req && !bus.dmem_ready;
    assign w_waitCntInc = r_waitCnt + WAIT_BITS'(1);
    assign w_timeout    = (w_waitCntInc == WAIT_BITS'(TIMEOUT));

    // Priority: memory freeze, then redirect (ID is on the wrong path), then load-use bubble.
    always_comb begin
        w_nextState  = r_state;
        w_redirect   = 1'b0;
        w_pcWrite    = 1'b1;
        w_ifIdWrite  = 1'b1;
        w_idExWrite  = 1'b1;
        w_exMemWrite = 1'b1;
        w_memWbWrite = 1'b1;
        w_ifIdFlush  = 1'b0;
        w_idExBubble = 1'b0;
        if (reset_n) begin
            case (r_state)
                ERROR: begin
                    w_pcWrite    = 1'b0;
                    w_ifIdWrite  = 1'b0;
                    w_idExWrite  = 1'b0;
                    w_exMemWrite = 1'b0;
                    w_memWbWrite = 1'b0;
                end
                default: begin
                    if (w_memStall) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdWrite  = 1'b0;
                        w_idExWrite  = 1'b0;
                        w_exMemWrite = 1'b0;
                        w_memWbWrite = 1'b0;
                        w_nextState  = ((r_state == MEM_WAIT) && w_timeout) ? ERROR : MEM_WAIT;
                    end else if (bus.branch_taken) begin
                        w_redirect   = 1'b1;
                        w_ifIdFlush  = 1'b1;
                        w_idExBubble = 1'b1;
                        w_nextState  = RUN;
                    end else if (w_hazard) begin
                        w_pcWrite    = 1'b0;
                        w_ifIdWrite  = 1'b0;
                        w_idExBubble = 1'b1;
                        w_nextState  = RUN;
                    end else begin
                        w_nextState  = RUN;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RUN;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_waitCnt <= '0;
        end else if (w_memStall && (r_state == RUN)) begin
            r_waitCnt <= '0;
        end else if (w_memStall && (r_state == MEM_WAIT)) begin
            r_waitCnt <= w_waitCntInc;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stallCycles <= '0;
            r_flushCount  <= '0;
        end else if (r_state != ERROR) begin
            if (!w_pcWrite) begin
                r_stallCycles <= r_stallCycles + CNT_W'(1);
            end
            if (w_redirect) begin
                r_flushCount <= r_flushCount + CNT_W'(1);
            end
        end
    end

    assign bus.pc_write     = w_pcWrite;
    assign bus.if_id_write  = w_ifIdWrite;
    assign bus.id_ex_write  = w_idExWrite;
    assign bus.ex_mem_write = w_exMemWrite;
    assign bus.mem_wb_write = w_memWbWrite;
    assign bus.if_id_flush  = w_ifIdFlush;
    assign bus.id_ex_bubble = w_idExBubble;
    assign bus.bus_error    = (r_state == ERROR);
    assign bus.stall_cycles = r_stallCycles;
    assign bus.flush_count  = r_flushCount;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: combinational vector table plus multi-cycle stall/timeout sequences.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 16;
    localparam int TIMEOUT = 4;

    // Output vector order: {pc, if_id, id_ex, ex_mem, mem_wb, flush, bubble}
    localparam logic [6:0] OUT_RUN    = 7'b1111100;
    localparam logic [6:0] OUT_LOAD   = 7'b0011101;
    localparam logic [6:0] OUT_REDIR  = 7'b1111111;
    localparam logic [6:0] OUT_FREEZE = 7'b0000000;

    typedef struct packed {
        logic       exMemRead;
        logic [4:0] exRd;
        logic [4:0] idRs1;
        logic [4:0] idRs2;
        logic       usesRs1;
        logic       usesRs2;
        logic       branch;
        logic       dmemReq;
        logic       dmemReady;
        logic [6:0] expOut;
    } vec_t;

    logic clk;
    logic reset_n;
    int   testsRun;
    int   testsFailed;
    vec_t vecs[$];

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mkVec(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                                   input logic [4:0] rs2, input logic u1, input logic u2,
                                   input logic br, input logic req, input logic rdy,
                                   input logic [6:0] expOut);
        vec_t v;
        v.exMemRead = mr;
        v.exRd      = rd;
        v.idRs1     = rs1;
        v.idRs2     = rs2;
        v.usesRs1   = u1;
        v.usesRs2   = u2;
        v.branch    = br;
        v.dmemReq   = req;
        v.dmemReady = rdy;
        v.expOut    = expOut;
        return v;
    endfunction

    function automatic logic [6:0] packOut();
        return {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write,
                bus.mem_wb_write, bus.if_id_flush, bus.id_ex_bubble};
    endfunction

    task automatic applyStimulus(input vec_t v);
        bus.ex_mem_read  = v.exMemRead;
        bus.ex_rd        = v.exRd;
        bus.id_rs1       = v.idRs1;
        bus.id_rs2       = v.idRs2;
        bus.id_uses_rs1  = v.usesRs1;
        bus.id_uses_rs2  = v.usesRs2;
        bus.branch_taken = v.branch;
        bus.dmem_req     = v.dmemReq;
        bus.dmem_ready   = v.dmemReady;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        reset_n = 1'b0;
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 0, 0, 0, OUT_RUN));
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int expStall;
        int expFlush;
        vec_t idle;
        vec_t loadUse;
        vec_t memWaitBr;
        vec_t memHold;

        testsRun    = 0;
        testsFailed = 0;
        idle      = mkVec(0, 0,  0, 0, 0, 0, 0, 0, 0, OUT_RUN);
        loadUse   = mkVec(1, 5,  5, 0, 1, 0, 0, 0, 0, OUT_LOAD);
        memWaitBr = mkVec(0, 0,  0, 0, 0, 0, 1, 1, 0, OUT_FREEZE);
        memHold   = mkVec(0, 0,  0, 0, 0, 0, 0, 1, 0, OUT_FREEZE);

        vecs.push_back(idle);
        vecs.push_back(loadUse);
        vecs.push_back(mkVec(1, 0,  0, 0, 1, 0, 0, 0, 0, OUT_RUN));
        vecs.push_back(mkVec(1, 7,  3, 7, 1, 1, 0, 0, 0, OUT_LOAD));
        vecs.push_back(mkVec(1, 7,  7, 0, 0, 0, 0, 0, 0, OUT_RUN));
        vecs.push_back(mkVec(0, 7,  7, 7, 1, 1, 0, 0, 0, OUT_RUN));
        vecs.push_back(mkVec(0, 0,  0, 0, 0, 0, 1, 0, 0, OUT_REDIR));
        vecs.push_back(mkVec(1, 9,  9, 0, 1, 0, 1, 0, 0, OUT_REDIR));
        vecs.push_back(mkVec(0, 0,  0, 0, 0, 0, 0, 1, 0, OUT_FREEZE));
        vecs.push_back(mkVec(1, 9,  9, 0, 1, 0, 1, 1, 0, OUT_FREEZE));
        vecs.push_back(mkVec(0, 0,  0, 0, 0, 0, 0, 0, 1, OUT_RUN));
        vecs.push_back(mkVec(0, 0,  0, 0, 0, 0, 0, 1, 1, OUT_RUN));
        vecs.push_back(mkVec(1, 12, 0, 12, 0, 1, 0, 1, 1, OUT_LOAD));

        // Reset state, sampled while reset is still asserted
        reset_n = 1'b0;
        applyStimulus(loadUse);
        #1;
        checkOutput("reset_outs", packOut(), OUT_RUN);
        checkOutput("reset_bus_error", bus.bus_error, 0);
        checkOutput("reset_stall_cycles", bus.stall_cycles, 0);
        checkOutput("reset_flush_count", bus.flush_count, 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Vector table, one clock per vector; counters tallied from expected outputs
        expStall = 0;
        expFlush = 0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("vec%0d_outs", i), packOut(), vecs[i].expOut);
            if (!vecs[i].expOut[6]) expStall++;
            if (vecs[i].expOut[1] && vecs[i].expOut[6]) expFlush++;
            @(negedge clk);
        end
        checkOutput("table_stall_cycles", bus.stall_cycles, expStall);
        checkOutput("table_flush_count", bus.flush_count, expFlush);

        // Single load-use bubble
        resetDut();
        applyStimulus(loadUse);
        #1;
        checkOutput("loaduse_outs", packOut(), OUT_LOAD);
        @(negedge clk);
        checkOutput("loaduse_stall_cycles", bus.stall_cycles, 1);
        applyStimulus(idle);
        #1;
        checkOutput("loaduse_next_outs", packOut(), OUT_RUN);
        @(negedge clk);
        checkOutput("loaduse_stall_hold", bus.stall_cycles, 1);

        // Load into x0 never stalls
        resetDut();
        applyStimulus(mkVec(1, 0, 0, 0, 1, 0, 0, 0, 0, OUT_RUN));
        #1;
        checkOutput("x0_outs", packOut(), OUT_RUN);
        @(negedge clk);
        checkOutput("x0_stall_cycles", bus.stall_cycles, 0);

        // Branch wins over a concurrent load-use match
        resetDut();
        applyStimulus(mkVec(1, 5, 5, 0, 1, 0, 1, 0, 0, OUT_REDIR));
        #1;
        checkOutput("brhaz_outs", packOut(), OUT_REDIR);
        @(negedge clk);
        checkOutput("brhaz_flush_count", bus.flush_count, 1);
        checkOutput("brhaz_stall_cycles", bus.stall_cycles, 0);

        // Three-cycle memory wait with a branch held in EX
        resetDut();
        applyStimulus(memWaitBr);
        for (int k = 0; k < 3; k++) begin
            #1;
            checkOutput($sformatf("memwait_c%0d_outs", k + 1), packOut(), OUT_FREEZE);
            @(negedge clk);
        end
        checkOutput("memwait_stall_cycles", bus.stall_cycles, 3);
        checkOutput("memwait_flush_before", bus.flush_count, 0);
        bus.dmem_ready = 1'b1;
        #1;
        checkOutput("memwait_c4_outs", packOut(), OUT_REDIR);
        @(negedge clk);
        checkOutput("memwait_flush_after", bus.flush_count, 1);
        checkOutput("memwait_stall_after", bus.stall_cycles, 3);
        applyStimulus(idle);

        // Timeout: one RUN stall cycle, then four MEM_WAIT cycles reach TIMEOUT
        resetDut();
        applyStimulus(memHold);
        for (int k = 1; k <= 5; k++) begin
            #1;
            checkOutput($sformatf("timeout_c%0d_outs", k), packOut(), OUT_FREEZE);
            @(negedge clk);
            if (k == 4) checkOutput("timeout_no_error_yet", bus.bus_error, 0);
        end
        checkOutput("timeout_bus_error", bus.bus_error, 1);
        checkOutput("timeout_stall_cycles", bus.stall_cycles, 5);
        applyStimulus(mkVec(0, 0, 0, 0, 0, 0, 1, 0, 0, OUT_FREEZE));
        #1;
        checkOutput("error_outs", packOut(), OUT_FREEZE);
        @(negedge clk);
        checkOutput("error_sticky", bus.bus_error, 1);
        checkOutput("error_stall_frozen", bus.stall_cycles, 5);
        checkOutput("error_flush_frozen", bus.flush_count, 0);

        // Asynchronous reset between clock edges leaves ERROR at once
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("areset_bus_error", bus.bus_error, 0);
        checkOutput("areset_stall_cycles", bus.stall_cycles, 0);
        checkOutput("areset_outs", packOut(), OUT_RUN);
        @(negedge clk);
        reset_n = 1'b1;
        applyStimulus(idle);
        #1;
        checkOutput("post_reset_outs", packOut(), OUT_RUN);
        @(negedge clk);
        checkOutput("post_reset_bus_error", bus.bus_error, 0);
        checkOutput("post_reset_flush", bus.flush_count, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
